fifo_drain_ctrl: RTL and testbench
==================================

FIFO_DRAIN_CTRL -- requirements
Module: fifo_drain_ctrl

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 16: data word width, matching the FIFO it drains.
REQ-002 SHALL have parameter BUF_DEPTH, fixed at 3: output buffer entries, sized to cover the FIFO's 1-cycle read latency at full throughput.
REQ-003 SHALL have port clk  input  1  clock; every flop is on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port drain_en  input  1  1 = issue FIFO pops; 0 = stop issuing and let in-flight words complete.
REQ-006 SHALL have port fifo_empty  input  1  FIFO empty flag.
REQ-007 SHALL have port fifo_data_out  input  FIFO_WIDTH  FIFO read data, registered, valid 1 cycle after an accepted fifo_rd_en.
REQ-008 SHALL have port fifo_underflow  input  1  FIFO underflow flag, 1 cycle after a rejected read.
REQ-009 SHALL have port fifo_rd_en  output  1  FIFO pop request.
REQ-010 SHALL have port out_data  output  FIFO_WIDTH  downstream data, driven from the buffer head.
REQ-011 SHALL have port out_valid  output  1  buffer head holds a word.
REQ-012 SHALL have port out_ready  input  1  downstream accepts; a word transfers when out_valid && out_ready at a rising edge.
REQ-013 SHALL have port busy  output  1  state != IDLE.
REQ-014 SHALL have port err_underflow  output  1  sticky flag: a pop returned underflow.
REQ-015 SHALL have port err_clr  input  1  synchronous clear of err_underflow (and of words_out when DRAIN_STATS_EN is defined).

Function
REQ-016 SHALL keep occ (0..3, buffered words) and infl (0..1, pops awaiting data) as registered counters.
REQ-017 SHALL drive fifo_rd_en = drain_en && !fifo_empty && (occ + infl < 3) && state != STOPPING, combinationally; fifo_rd_en SHALL NOT depend on out_ready.
REQ-018 SHALL set infl to 1 in the cycle after fifo_rd_en=1, otherwise to 0.
REQ-019 SHALL, when infl=1 and fifo_underflow=0, write fifo_data_out into the buffer tail in that cycle.
REQ-020 SHALL, when infl=1 and fifo_underflow=1, discard the word, set err_underflow, and leave occ unchanged.
REQ-021 SHALL keep strict FIFO order at the output; out_data SHALL hold stable while out_valid=1 and out_ready=0.
REQ-022 SHALL apply a simultaneous buffer write and output transfer in the same cycle, leaving occ unchanged; occ SHALL never exceed 3 or wrap.
REQ-023 SHALL sustain 1 word/cycle throughput when the FIFO is non-empty, out_ready=1, and the pipeline is primed (first word out_valid 2 cycles after the first fifo_rd_en).
REQ-024 SHALL implement FSM IDLE / ACTIVE / STOPPING.
REQ-025 FSM transitions SHALL be: IDLE -> ACTIVE when drain_en=1; ACTIVE -> STOPPING when drain_en=0 and (occ>0 or infl>0); ACTIVE -> IDLE when drain_en=0 with occ=infl=0; STOPPING -> IDLE when occ=0 and infl=0.
REQ-026 SHALL, in STOPPING, still capture in-flight data and present the buffer; drain_en rising in STOPPING SHALL be ignored until IDLE is reached.
REQ-027 SHALL give err_clr and a new underflow event in the same cycle precedence to the set.

Reset
REQ-028 SHALL, on rst_n=0 (including mid-transfer), immediately force occ=0, infl=0, state=IDLE, out_valid=0, out_data=0, err_underflow=0, busy=0, and words_out=0 when present; fifo_rd_en SHALL be 0 while rst_n=0.
REQ-029 SHALL drop buffered and in-flight words at reset without delivering them.

Configuration
REQ-030 SHALL, when macro FIFO_DRAIN_STATS_EN is defined, add output words_out (16 bits), which increments on each output transfer, saturates at 16'hFFFF, and clears on err_clr.
REQ-031 SHALL, when FIFO_DRAIN_STATS_EN is undefined, have no words_out port or counter, with all other behaviour identical.

Verification
REQ-032 Bench SHALL cover: FIFO preloaded with 0x0001..0x0008, drain_en=1, out_ready=1 -> out_data 0x0001..0x0008 on 8 consecutive cycles, first out_valid 2 cycles after first fifo_rd_en.
REQ-033 Bench SHALL cover: out_ready=0 with 5 words in the FIFO -> exactly 3 pops, occ=3, fifo_rd_en held 0; out_ready=1 -> remaining 2 words popped, order kept.
REQ-034 Bench SHALL cover: drain_en dropped with occ=2, infl=1 -> state STOPPING, 3 words delivered, then IDLE with busy=0, no further pops.
REQ-035 Bench SHALL cover: fifo_underflow forced 1 in the cycle after a pop -> err_underflow=1, occ unchanged; err_clr=1 for 1 cycle -> err_underflow=0.
REQ-036 Bench SHALL cover: rst_n pulsed low with occ=3 -> out_valid=0, occ=0, state=IDLE immediately, before the next clk edge.
REQ-037 Bench SHALL cover: with FIFO_DRAIN_STATS_EN defined, 10 transfers -> words_out=10; err_clr -> 0; forced value 0xFFFF plus one transfer -> words_out stays 0xFFFF.

Source files
------------

// File: rtl/fifo_drain_ctrl.sv
// fifo_drain_ctrl: pops a registered-output FIFO into a 3-entry skid buffer and presents words downstream.
// Latency: first word out_valid 2 cycles after the first fifo_rd_en; 1 word/cycle sustained once primed.
// Backpressure: pops are issued only while buffered plus in-flight words stay below 3, never from out_ready.
//
// Ports: clk, rst_n (async active-low); drain_en starts/stops popping; fifo_empty/fifo_data_out/
// fifo_underflow/fifo_rd_en talk to the FIFO; out_data/out_valid/out_ready form the downstream
// handshake; busy is high outside IDLE; err_underflow is sticky, cleared by err_clr.
// Optional macro FIFO_DRAIN_STATS_EN adds words_out, a saturating 16-bit transfer counter.
module fifo_drain_ctrl #(
  parameter int FIFO_WIDTH = 16,
  parameter int BUF_DEPTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  drain_en,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic [FIFO_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic                  err_underflow,
  input  logic                  err_clr
`ifdef FIFO_DRAIN_STATS_EN
  ,
  output logic [15:0]           words_out
`endif
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [1:0] occ, occ_nxt;      // buffered words, 0..3
  logic       infl;              // a pop was issued last cycle, its data arrives now
  logic [2:0] pending;
  logic       push, xfer;
  logic [1:0] wr_idx;

  // Entry 0 is always the head; a transfer shifts the buffer down by one.
  logic [FIFO_WIDTH-1:0] mem     [BUF_DEPTH];
  logic [FIFO_WIDTH-1:0] mem_nxt [BUF_DEPTH];

  assign pending   = {1'b0, occ} + {2'b00, infl};
  assign push      = infl && !fifo_underflow;
  assign out_valid = (occ != 2'd0);
  assign xfer      = out_valid && out_ready;
  assign out_data  = mem[0];
  assign busy      = (state != IDLE);

  // Counting in-flight pops against the buffer keeps the returning word guaranteed a slot,
  // so the pop decision never has to look at out_ready.
  assign fifo_rd_en = rst_n && drain_en && !fifo_empty && (pending < 3'd3) && (state != STOPPING);

  // With a simultaneous transfer the tail slot moves down one place before the write lands.
  assign wr_idx = xfer ? (occ - 2'd1) : occ;

  always_comb begin
    mem_nxt = mem;
    if (xfer) begin
      for (int i = 0; i < BUF_DEPTH - 1; i++) begin
        mem_nxt[i] = mem[i+1];
      end
      mem_nxt[BUF_DEPTH-1] = '0;
    end
    if (push && (wr_idx < 2'(BUF_DEPTH))) begin
      mem_nxt[wr_idx] = fifo_data_out;
    end
  end

  always_comb begin
    occ_nxt = occ;
    case ({push, xfer})
      2'b10:   occ_nxt = occ + 2'd1;
      2'b01:   occ_nxt = occ - 2'd1;
      default: occ_nxt = occ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (drain_en) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (!drain_en) begin
          if ((occ != 2'd0) || infl) state_nxt = STOPPING;
          else                       state_nxt = IDLE;
        end
      end
      STOPPING: begin
        // drain_en is deliberately ignored here; only an empty pipeline ends the drain.
        if ((occ == 2'd0) && !infl) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      occ   <= 2'd0;
      infl  <= 1'b0;
      mem   <= '{default: '0};
    end else begin
      state <= state_nxt;
      occ   <= occ_nxt;
      infl  <= fifo_rd_en;
      mem   <= mem_nxt;
    end
  end

  // A new underflow wins over a same-cycle clear so the event is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_underflow <= 1'b0;
    end else if (infl && fifo_underflow) begin
      err_underflow <= 1'b1;
    end else if (err_clr) begin
      err_underflow <= 1'b0;
    end
  end

`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] words_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      words_cnt <= 16'd0;
    end else if (err_clr) begin
      words_cnt <= 16'd0;
    end else if (xfer && (words_cnt != 16'hFFFF)) begin
      words_cnt <= words_cnt + 16'd1;
    end
  end

  assign words_out = words_cnt;
`endif

endmodule

// File: tb/tb_fifo_drain_ctrl.sv
// Bench for fifo_drain_ctrl: behavioural FIFO model, scoreboard of expected output words,
// and a monitor that checks every downstream transfer against the scoreboard.
module tb_fifo_drain_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        drain_en;
  logic        fifo_empty = 1'b1;
  logic [15:0] fifo_data_out = 16'h0;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        err_underflow;
  logic        err_clr;
`ifdef FIFO_DRAIN_STATS_EN
  logic [15:0] words_out;
`endif

  fifo_drain_ctrl #(.FIFO_WIDTH(16), .BUF_DEPTH(3)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .drain_en       (drain_en),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .busy           (busy),
    .err_underflow  (err_underflow),
    .err_clr        (err_clr)
`ifdef FIFO_DRAIN_STATS_EN
    ,
    .words_out      (words_out)
`endif
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          pops = 0;
  logic [15:0] fifo_q [$];
  logic [15:0] exp_q  [$];
  int          xfer_cyc [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // FIFO model: registered read data; the word 16'hDEAD comes back flagged as underflow.
  always @(posedge clk) begin
    logic [15:0] w;
    fifo_underflow <= 1'b0;
    if (fifo_rd_en) begin
      pops++;
      if (fifo_q.size() == 0) begin
        fifo_underflow <= 1'b1;
      end else begin
        w = fifo_q.pop_front();
        fifo_data_out <= w;
        if (w == 16'hDEAD) fifo_underflow <= 1'b1;
      end
    end
    fifo_empty <= (fifo_q.size() == 0);
  end

  // Monitor: samples between the input-drive edge and the active edge.
  always @(negedge clk) begin
    logic [15:0] e;
    #2;
    if (rst_n && out_valid && out_ready) begin
      xfer_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual=%0h required=none", out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", 32'(out_data), 32'(e));
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_drain(input string nm);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      #3;
      if (exp_q.size() == 0) break;
    end
    chk({nm, "_drained"}, 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int first_rd, first_ov;
    rst_n = 1'b0; drain_en = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
    tick(3);
    #1;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data",  32'(out_data),  32'd0);
    chk("rst_rd_en",     32'(fifo_rd_en), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("rst_err",       32'(err_underflow), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Streaming: 0x0001..0x0008 back to back
    xfer_cyc.delete();
    for (int i = 1; i <= 8; i++) begin
      fifo_q.push_back(16'(i));
      exp_q.push_back(16'(i));
    end
    out_ready = 1'b1;
    drain_en  = 1'b1;
    first_rd = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (fifo_rd_en) begin first_rd = cyc; break; end
    end
    chk("t1_rd_seen", 32'(first_rd >= 0), 32'd1);
    first_ov = -1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (out_valid) begin first_ov = cyc; break; end
    end
    chk("t1_latency", 32'(first_ov - first_rd), 32'd2);
    wait_drain("t1");
    chk("t1_count", 32'(xfer_cyc.size()), 32'd8);
    if (xfer_cyc.size() == 8)
      chk("t1_span", 32'(xfer_cyc[7] - xfer_cyc[0]), 32'd7);
    drain_en = 1'b0;
    tick(3); #1;
    chk("t1_busy", 32'(busy), 32'd0);

    // Backpressure: 5 words, out_ready low
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) begin
      fifo_q.push_back(16'h0010 + 16'(i));
      exp_q.push_back(16'h0010 + 16'(i));
    end
    drain_en = 1'b1;
    tick(8); #1;
    chk("t2_pops", 32'(pops), 32'd3);
    chk("t2_occ",  32'(dut.occ), 32'd3);
    chk("t2_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("t2_fifo_left", 32'(fifo_q.size()), 32'd2);
    out_ready = 1'b1;
    wait_drain("t2");
    chk("t2_pops_total", 32'(pops), 32'd5);
    drain_en = 1'b0;
    tick(3); #1;
    chk("t2_busy", 32'(busy), 32'd0);

    // Stop with occ=2, infl=1
    out_ready = 1'b0;
    pops = 0;
    for (int i = 0; i < 5; i++) fifo_q.push_back(16'h0021 + 16'(i));
    for (int i = 0; i < 3; i++) exp_q.push_back(16'h0021 + 16'(i));
    drain_en = 1'b1;
    first_rd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (dut.occ == 2'd2 && dut.infl) begin first_rd = 1; break; end
    end
    chk("t3_occ2_infl1", 32'(first_rd), 32'd1);
    drain_en = 1'b0;
    @(negedge clk); #1;
    chk("t3_stopping", 32'(dut.state), 32'd2);
    chk("t3_busy", 32'(busy), 32'd1);
    drain_en = 1'b1;
    #1;
    chk("t3_rd_ignored", 32'(fifo_rd_en), 32'd0);
    @(negedge clk); #1;
    chk("t3_still_stopping", 32'(dut.state), 32'd2);
    drain_en = 1'b0;
    out_ready = 1'b1;
    wait_drain("t3");
    tick(2); #1;
    chk("t3_idle", 32'(dut.state), 32'd0);
    chk("t3_idle_busy", 32'(busy), 32'd0);
    chk("t3_pops", 32'(pops), 32'd3);
    chk("t3_fifo_left", 32'(fifo_q.size()), 32'd2);
    fifo_q.delete();
    tick(2);

    // Underflow on a pop, then clear; then clear colliding with a new underflow
    out_ready = 1'b0;
    fifo_q.push_back(16'hDEAD);
    fifo_q.push_back(16'h0031);
    exp_q.push_back(16'h0031);
    drain_en = 1'b1;
    first_rd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (err_underflow) begin first_rd = 1; break; end
    end
    chk("t4_err_set", 32'(first_rd), 32'd1);
    chk("t4_occ_kept", 32'(dut.occ), 32'd0);
    @(negedge clk); #1;
    chk("t4_occ_next", 32'(dut.occ), 32'd1);
    chk("t4_head", 32'(out_data), 32'h0031);
    chk("t4_sticky", 32'(err_underflow), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("t4_err_clr", 32'(err_underflow), 32'd0);
    fifo_q.push_back(16'hDEAD);
    first_rd = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk); #1;
      if (fifo_underflow) begin first_rd = 1; break; end
    end
    chk("t4_uf2_seen", 32'(first_rd), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("t4_set_wins", 32'(err_underflow), 32'd1);
    chk("t4_occ_after2", 32'(dut.occ), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    out_ready = 1'b1;
    wait_drain("t4");
    drain_en = 1'b0;
    tick(3);

    // Reset mid-transfer with a full buffer
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) fifo_q.push_back(16'h0041 + 16'(i));
    drain_en = 1'b1;
    first_rd = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk); #1;
      if (dut.occ == 2'd3) begin first_rd = 1; break; end
    end
    chk("t5_full", 32'(first_rd), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_occ",   32'(dut.occ), 32'd0);
    chk("t5_infl",  32'(dut.infl), 32'd0);
    chk("t5_state", 32'(dut.state), 32'd0);
    chk("t5_busy",  32'(busy), 32'd0);
    chk("t5_data",  32'(out_data), 32'd0);
    chk("t5_rd_en", 32'(fifo_rd_en), 32'd0);
    drain_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    tick(5); #1;
    chk("t5_no_replay", 32'(out_valid), 32'd0);

`ifdef FIFO_DRAIN_STATS_EN
    chk("t6_cnt_reset", 32'(words_out), 32'd0);
    for (int i = 0; i < 10; i++) begin
      fifo_q.push_back(16'h0051 + 16'(i));
      exp_q.push_back(16'h0051 + 16'(i));
    end
    drain_en = 1'b1;
    wait_drain("t6");
    tick(1); #1;
    chk("t6_cnt10", 32'(words_out), 32'd10);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    #1;
    chk("t6_cnt_clr", 32'(words_out), 32'd0);
    force dut.words_cnt = 16'hFFFF;
    #1;
    release dut.words_cnt;
    fifo_q.push_back(16'h0061);
    exp_q.push_back(16'h0061);
    wait_drain("t6b");
    tick(1); #1;
    chk("t6_saturate", 32'(words_out), 32'hFFFF);
    drain_en = 1'b0;
    tick(3);
`endif

    tick(2);
    chk("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
